// File: rtl/board_pkg.sv
// board_pkg: constants and types shared by the board generator and other
// random-number consumers.
//   state_e      - board generator FSM states
//   MAX_SIZE     - default maximum board edge length
//   DEFAULT_SEED - LFSR seed used when the caller supplies zero
//   lfsr_taps()  - maximal-length Fibonacci tap mask for a given width
package board_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StFill,
        StDone
    } state_e;

    localparam int unsigned MAX_SIZE     = 26;
    localparam logic [15:0] DEFAULT_SEED = 16'hDAD7;

    // Bit i set means R[i] feeds the XOR; the result shifts in at bit 0.
    localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;  // R15^R13^R12^R10

    function automatic logic [63:0] lfsr_taps(input int unsigned width);
        logic [63:0] taps;
        case (width)
            4:       taps = 64'h0000_0000_0000_000C;
            8:       taps = 64'h0000_0000_0000_00B8;
            12:      taps = 64'h0000_0000_0000_0E08;
            16:      taps = {48'd0, LFSR_TAPS_16};
            20:      taps = 64'h0000_0000_0009_0000;
            24:      taps = 64'h0000_0000_00E1_0000;
            32:      taps = 64'h0000_0000_8020_0003;
            // Unlisted widths degenerate to a plain shifter; add an entry before using one.
            default: taps = 64'd0;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// lfsr_step: Fibonacci LFSR that advances one step per enabled cycle.
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset to RESET_VALUE
//   load   - load seed (takes priority over enable)
//   enable - advance one step
//   seed   - value loaded by load
//   state  - current register value
module lfsr_step
    import board_pkg::*;
#(
    parameter int unsigned          WIDTH       = 16,
    parameter logic [WIDTH-1:0]     RESET_VALUE = WIDTH'(board_pkg::DEFAULT_SEED)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] state
);

    localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = seed;
        end else if (enable) begin
            state_d = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RESET_VALUE;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/board_generator.sv
// board_generator: fills a SIZE x SIZE board with random colours, one cell
// write per accepted LFSR sample, in row-major order.
//   CLOCK, RESET        - clock and synchronous active-high reset
//   START               - level request; a new board needs START low after DONE
//   SEED                - LFSR seed (zero selects DEFAULT_SEED)
//   SIZE, COLOR_NUM     - board edge and colour count, clamped and latched in LOAD
//   WR_EN/ROW/COL/COLOR - cell write strobe and payload (payload zero when idle)
//   BUSY, DONE          - status
module board_generator
    import board_pkg::*;
#(
    parameter int unsigned              MAX_SIZE     = board_pkg::MAX_SIZE,
    parameter int unsigned              COLOR_W      = 3,
    parameter int unsigned              LFSR_W       = 16,
    parameter logic [LFSR_W-1:0]        DEFAULT_SEED = LFSR_W'(board_pkg::DEFAULT_SEED)
) (
    input  logic                          CLOCK,
    input  logic                          RESET,
    input  logic                          START,
    input  logic [LFSR_W-1:0]             SEED,
    input  logic [$clog2(MAX_SIZE+1)-1:0] SIZE,
    input  logic [COLOR_W:0]              COLOR_NUM,
    output logic                          WR_EN,
    output logic [$clog2(MAX_SIZE)-1:0]   WR_ROW,
    output logic [$clog2(MAX_SIZE)-1:0]   WR_COL,
    output logic [COLOR_W-1:0]            WR_COLOR,
    output logic                          BUSY,
    output logic                          DONE
);

    localparam int unsigned SIZE_W = $clog2(MAX_SIZE + 1);
    localparam int unsigned POS_W  = $clog2(MAX_SIZE);
    localparam int unsigned CN_W   = COLOR_W + 1;

    localparam logic [SIZE_W-1:0] SIZE_MIN   = SIZE_W'(2);
    localparam logic [SIZE_W-1:0] SIZE_MAX   = SIZE_W'(MAX_SIZE);
    localparam logic [CN_W-1:0]   COLORS_MIN = CN_W'(2);
    localparam logic [CN_W-1:0]   COLORS_MAX = {1'b1, {COLOR_W{1'b0}}};

    state_e              state_q, state_d;
    logic [SIZE_W-1:0]   size_q, size_d;
    logic [CN_W-1:0]     colors_q, colors_d;
    logic [POS_W-1:0]    row_q, row_d;
    logic [POS_W-1:0]    col_q, col_d;

    logic [LFSR_W-1:0]   lfsr_state;
    logic [LFSR_W-1:0]   seed_sel;
    logic                lfsr_load;
    logic                lfsr_enable;
    logic [COLOR_W-1:0]  sample;
    logic                accept;
    logic                col_last;
    logic                row_last;
    logic                unused_lfsr;

    assign seed_sel    = (SEED == '0) ? DEFAULT_SEED : SEED;
    assign lfsr_load   = (state_q == StLoad);
    assign lfsr_enable = (state_q == StFill);

    lfsr_step #(
        .WIDTH       (LFSR_W),
        .RESET_VALUE (DEFAULT_SEED)
    ) u_lfsr (
        .clk    (CLOCK),
        .rst    (RESET),
        .load   (lfsr_load),
        .enable (lfsr_enable),
        .seed   (seed_sel),
        .state  (lfsr_state)
    );

    // Only the low bits form a colour; the rest only feed the shift sequence.
    assign sample      = lfsr_state[COLOR_W-1:0];
    assign unused_lfsr = ^lfsr_state;

    // Out-of-range samples are dropped rather than folded, keeping colours unbiased.
    assign accept   = (state_q == StFill) && ({1'b0, sample} < colors_q);
    assign col_last = (SIZE_W'(col_q) + SIZE_W'(1)) == size_q;
    assign row_last = (SIZE_W'(row_q) + SIZE_W'(1)) == size_q;

    always_comb begin
        state_d  = state_q;
        size_d   = size_q;
        colors_d = colors_q;
        row_d    = row_q;
        col_d    = col_q;
        WR_EN    = 1'b0;
        WR_ROW   = '0;
        WR_COL   = '0;
        WR_COLOR = '0;

        unique case (state_q)
            StIdle: begin
                if (START) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                size_d   = (SIZE < SIZE_MIN) ? SIZE_MIN :
                           (SIZE > SIZE_MAX) ? SIZE_MAX : SIZE;
                colors_d = (COLOR_NUM < COLORS_MIN) ? COLORS_MIN :
                           (COLOR_NUM > COLORS_MAX) ? COLORS_MAX : COLOR_NUM;
                row_d    = '0;
                col_d    = '0;
                state_d  = StFill;
            end
            StFill: begin
                if (accept) begin
                    WR_EN    = 1'b1;
                    WR_ROW   = row_q;
                    WR_COL   = col_q;
                    WR_COLOR = sample;
                    if (col_last) begin
                        col_d = '0;
                        row_d = row_q + POS_W'(1);
                        if (row_last) begin
                            state_d = StDone;
                        end
                    end else begin
                        col_d = col_q + POS_W'(1);
                    end
                end
            end
            StDone: begin
                if (!START) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign BUSY = (state_q == StLoad) || (state_q == StFill);
    assign DONE = (state_q == StDone);

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q  <= StIdle;
            size_q   <= '0;
            colors_q <= '0;
            row_q    <= '0;
            col_q    <= '0;
        end else begin
            state_q  <= state_d;
            size_q   <= size_d;
            colors_q <= colors_d;
            row_q    <= row_d;
            col_q    <= col_d;
        end
    end

endmodule
